// File: rtl/tx_frame_sequencer.sv
// tx_frame_sequencer
// Frame-level controller ahead of the Pack -> Spread -> QPSK transmit chain.
// Each start request sends one frame to Pack as a serial bit stream:
// preamble (MSB first), then PAYLOAD_LEN bits pulled from the upstream
// source, then GUARD_CYCLES idle clocks so the downstream pipeline drains.
//
// Ports
//   i_clk, i_reset          clock, asynchronous active-low reset
//   i_start                 frame request (pulse or level)
//   i_abort                 drop the current frame, return to IDLE
//   i_bit, i_bit_valid      upstream payload bit source
//   o_bit_ready             upstream accept (combinational)
//   i_ready                 downstream (Spread) ready
//   o_data, o_valid         registered serial output to Pack
//   o_busy                  any state but IDLE
//   o_frame_done            one-clock pulse in the last guard cycle
//   o_bit_cnt               payload bits transferred in the current frame
module tx_frame_sequencer #(
  parameter int          PREAMBLE_LEN = 32,
  parameter logic [31:0] PREAMBLE     = 32'hF0F0_CC33,
  parameter int          PAYLOAD_LEN  = 256,
  parameter int          GUARD_CYCLES = 48,
  parameter int          CNT_W        = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic             i_bit,
  input  logic             i_bit_valid,
  output logic             o_bit_ready,
  input  logic             i_ready,
  output logic             o_data,
  output logic             o_valid,
  output logic             o_busy,
  output logic             o_frame_done,
  output logic [CNT_W-1:0] o_bit_cnt
);

  localparam int PI_W = (PREAMBLE_LEN > 1) ? $clog2(PREAMBLE_LEN) : 1;
  localparam logic [PI_W-1:0]  PRE_TOP  = PI_W'(PREAMBLE_LEN - 1);
  localparam logic [CNT_W-1:0] PAY_N    = CNT_W'(PAYLOAD_LEN);
  localparam logic [CNT_W-1:0] PAY_LAST = CNT_W'(PAYLOAD_LEN - 1);
  localparam logic [CNT_W-1:0] GRD_LAST = CNT_W'(GUARD_CYCLES - 1);
  localparam logic             GRD_ONE  = (GUARD_CYCLES == 1);

  typedef enum logic [1:0] {S_IDLE, S_PRE, S_PAY, S_GRD} state_e;

  state_e           state_q;
  logic [PI_W-1:0]  pre_idx_q;   // preamble bit currently held in data_q
  logic [CNT_W-1:0] loaded_q;    // payload bits taken from upstream
  logic [CNT_W-1:0] bit_cnt_q;   // payload bits handed downstream
  logic [CNT_W-1:0] guard_q;
  logic             pend_q;
  logic             data_q;
  logic             valid_q;
  logic             done_q;

  logic xfer, pre_last, accept, go;

  assign xfer     = valid_q && i_ready;
  assign pre_last = (state_q == S_PRE) && (pre_idx_q == '0);

  // The last preamble transfer also opens the upstream port so the first
  // payload bit lands in the output register with no bubble.
  assign o_bit_ready = ((state_q == S_PAY) && (loaded_q < PAY_N) && (!valid_q || i_ready))
                    || (pre_last && xfer);
  assign accept      = o_bit_ready && i_bit_valid;

  // Frame launch: from IDLE, or straight out of the final guard cycle.
  assign go = (i_start || pend_q) &&
              ((state_q == S_IDLE) || ((state_q == S_GRD) && (guard_q == GRD_LAST)));

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q   <= S_IDLE;
      pre_idx_q <= '0;
      loaded_q  <= '0;
      bit_cnt_q <= '0;
      guard_q   <= '0;
      pend_q    <= 1'b0;
      data_q    <= 1'b0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state_q != S_IDLE && i_start) pend_q <= 1'b1;

      if (i_abort) begin
        // Abort beats everything, including a start in the same clock.
        state_q <= S_IDLE;
        valid_q <= 1'b0;
        pend_q  <= 1'b0;
      end else if (go) begin
        state_q   <= S_PRE;
        pre_idx_q <= PRE_TOP;
        data_q    <= PREAMBLE[PRE_TOP];
        valid_q   <= 1'b1;
        loaded_q  <= '0;
        bit_cnt_q <= '0;
        pend_q    <= 1'b0;
      end else begin
        case (state_q)
          S_PRE: if (xfer) begin
            if (pre_last) begin
              state_q <= S_PAY;
              if (accept) begin
                data_q   <= i_bit;
                loaded_q <= CNT_W'(1);
              end else begin
                valid_q <= 1'b0;
              end
            end else begin
              pre_idx_q <= pre_idx_q - 1'b1;
              data_q    <= PREAMBLE[pre_idx_q - 1'b1];
            end
          end
          S_PAY: begin
            if (accept) begin
              data_q   <= i_bit;
              valid_q  <= 1'b1;
              loaded_q <= loaded_q + 1'b1;
            end else if (xfer) begin
              valid_q <= 1'b0;
            end
            if (xfer) begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
              if (bit_cnt_q == PAY_LAST) begin
                state_q <= S_GRD;
                valid_q <= 1'b0;
                guard_q <= '0;
                done_q  <= GRD_ONE;
              end
            end
          end
          S_GRD: begin
            if (guard_q == GRD_LAST) begin
              state_q <= S_IDLE;
            end else begin
              guard_q <= guard_q + 1'b1;
              // done is registered, so raise it entering the final guard cycle
              done_q  <= ((guard_q + 1'b1) == GRD_LAST);
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign o_data       = data_q;
  assign o_valid      = valid_q;
  assign o_busy       = (state_q != S_IDLE);
  assign o_frame_done = done_q;
  assign o_bit_cnt    = bit_cnt_q;

endmodule

// File: tb/tb_tx_frame_sequencer.sv
// Scoreboard bench for tx_frame_sequencer (8-bit preamble A5, 16-bit
// payload, 4 guard clocks). Expected bits are queued as frames are
// requested and as the upstream source hands bits over; a monitor pops and
// compares on every downstream transfer.
module tb_tx_frame_sequencer;

  logic        clk, rst_n;
  logic        i_start, i_abort, i_bit, i_bit_valid, i_ready;
  logic        o_bit_ready, o_data, o_valid, o_busy, o_frame_done;
  logic [15:0] o_bit_cnt;

  tx_frame_sequencer #(
    .PREAMBLE_LEN(8), .PREAMBLE(32'h0000_00A5), .PAYLOAD_LEN(16),
    .GUARD_CYCLES(4), .CNT_W(16)
  ) dut (
    .i_clk(clk), .i_reset(rst_n), .i_start(i_start), .i_abort(i_abort),
    .i_bit(i_bit), .i_bit_valid(i_bit_valid), .o_bit_ready(o_bit_ready),
    .i_ready(i_ready), .o_data(o_data), .o_valid(o_valid), .o_busy(o_busy),
    .o_frame_done(o_frame_done), .o_bit_cnt(o_bit_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_chk = 0, n_fail = 0, xfers = 0;
  logic        exp_q[$];
  logic [7:0]  pre = 8'hA5;
  logic [63:0] src = 64'h9E37_79B9_7F4A_7C15;
  logic [3:0]  rpat = 4'b1001;          // i_ready sequence 1,0,0,1
  bit          rdy_mode = 0, stall_en = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // monitor: compares every transfer, and checks hold-stable under stall
  logic mon_e, prev_stall = 0, prev_data = 0;
  initial begin
    forever begin
      @(negedge clk);
      if (prev_stall) begin
        check("hold_valid", 32'(o_valid), 1);
        check("hold_data", 32'(o_data), 32'(prev_data));
      end
      prev_stall = o_valid && !i_ready;
      prev_data  = o_data;
      if (o_valid && i_ready) begin
        xfers++;
        check("xfer_expected", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          check("data", 32'(o_data), 32'(mon_e));
        end
      end
    end
  end

  // upstream bit source; pushes each accepted bit to the scoreboard
  int sidx = 0, fcnt = 0, stall_left = 0;
  logic acc;
  initial begin
    i_bit_valid = 1'b1;
    i_bit = src[0];
    forever begin
      @(negedge clk);
      acc = o_bit_ready && i_bit_valid;
      if (!o_busy) fcnt = 0;
      if (acc) begin
        exp_q.push_back(i_bit);
        fcnt++;
        if (stall_en && fcnt == 6) stall_left = 10;
      end
      @(posedge clk); #1;
      if (acc) sidx++;
      i_bit = src[sidx % 64];
      if (stall_left > 0) begin
        i_bit_valid = 1'b0;
        stall_left--;
      end else i_bit_valid = 1'b1;
    end
  end

  // downstream ready driver
  int ph = 0;
  initial begin
    i_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (rdy_mode) begin
        i_ready = rpat[ph];
        ph = (ph + 1) % 4;
      end else i_ready = 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic start_frame();
    for (int k = 7; k >= 0; k--) exp_q.push_back(pre[k]);
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    check("first_valid_latency", 32'(o_valid), 1);
  endtask

  // Index 0 is the first cycle of the frame; i_start is raised in cycles pa/pb.
  task automatic run_frame(input int pa, input int pb, output int vc, output int lo, output int di);
    vc = 0; lo = 0; di = -1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (o_valid) vc++;
      else if (o_busy) lo++;
      i_start = (i == pa || i == pb);
      if (o_frame_done) begin
        di = i;
        break;
      end
    end
    i_start = 1'b0;
    check("frame_done_seen", 32'(di >= 0), 1);
  endtask

  int vc, lo, di, x0, busy_seen, done_seen, to;

  initial begin
    rst_n = 1'b0; i_start = 1'b0; i_abort = 1'b0;
    #12;
    check("rst_valid", 32'(o_valid), 0);
    check("rst_data", 32'(o_data), 0);
    check("rst_busy", 32'(o_busy), 0);
    check("rst_done", 32'(o_frame_done), 0);
    check("rst_bitcnt", 32'(o_bit_cnt), 0);
    check("rst_bit_ready", 32'(o_bit_ready), 0);
    tick();
    rst_n = 1'b1;
    repeat (2) tick();

    // single frame, no stalls
    x0 = xfers;
    start_frame();
    run_frame(-1, -1, vc, lo, di);
    check("t1_valid_run", 32'(vc), 24);
    check("t1_guard_low", 32'(lo), 4);
    check("t1_done_idx", 32'(di), 27);
    check("t1_bitcnt", 32'(o_bit_cnt), 16);
    check("t1_xfers", 32'(xfers - x0), 24);
    @(negedge clk);
    check("t1_done_one_clk", 32'(o_frame_done), 0);
    check("t1_idle", 32'(o_busy), 0);
    check("t1_q_empty", 32'(exp_q.size()), 0);

    // downstream backpressure 1,0,0,1
    tick();
    rdy_mode = 1;
    x0 = xfers;
    start_frame();
    run_frame(-1, -1, vc, lo, di);
    rdy_mode = 0;
    check("t2_guard_low", 32'(lo), 4);
    check("t2_bitcnt", 32'(o_bit_cnt), 16);
    check("t2_xfers", 32'(xfers - x0), 24);
    check("t2_q_empty", 32'(exp_q.size()), 0);

    // upstream stall of 10 clocks after payload bit 5
    tick(); tick();
    stall_en = 1;
    start_frame();
    run_frame(-1, -1, vc, lo, di);
    stall_en = 0;
    check("t3_valid_cycles", 32'(vc), 24);
    check("t3_low_cycles", 32'(lo), 14);
    check("t3_done_idx", 32'(di), 37);
    check("t3_bitcnt", 32'(o_bit_cnt), 16);
    check("t3_q_empty", 32'(exp_q.size()), 0);

    // back-to-back: two start pulses during payload collapse to one frame
    tick();
    start_frame();
    run_frame(12, 14, vc, lo, di);
    check("t4_f1_valid", 32'(vc), 24);
    check("t4_f1_guard", 32'(lo), 4);
    check("t4_f1_done_idx", 32'(di), 27);
    for (int k = 7; k >= 0; k--) exp_q.push_back(pre[k]);
    tick();
    check("t4_f2_start_valid", 32'(o_valid), 1);
    check("t4_f2_busy", 32'(o_busy), 1);
    check("t4_f2_bitcnt_clr", 32'(o_bit_cnt), 0);
    run_frame(-1, -1, vc, lo, di);
    check("t4_f2_valid", 32'(vc), 24);
    check("t4_f2_guard", 32'(lo), 4);
    check("t4_f2_done_idx", 32'(di), 27);
    busy_seen = 0; done_seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (o_frame_done) done_seen++;
      if (o_busy) busy_seen++;
    end
    check("t4_no_third_done", 32'(done_seen), 0);
    check("t4_no_third_busy", 32'(busy_seen), 0);
    check("t4_q_empty", 32'(exp_q.size()), 0);

    // abort at payload bit 7, with a start in the same clock
    tick();
    start_frame();
    to = 0;
    while (o_bit_cnt != 16'd7 && to < 100) begin
      tick();
      to++;
    end
    check("t5_reach_bit7", 32'(to < 100), 1);
    i_abort = 1'b1; i_start = 1'b1;
    tick();
    i_abort = 1'b0; i_start = 1'b0;
    check("t5_abort_valid", 32'(o_valid), 0);
    check("t5_abort_busy", 32'(o_busy), 0);
    check("t5_abort_done", 32'(o_frame_done), 0);
    check("t5_abort_bitcnt", 32'(o_bit_cnt), 7);
    exp_q.delete();
    repeat (3) tick();
    check("t5_start_dropped", 32'(o_busy), 0);
    i_abort = 1'b1; i_start = 1'b1;
    tick();
    i_abort = 1'b0; i_start = 1'b0;
    check("t5_idle_abort_wins", 32'(o_busy), 0);
    check("t5_idle_abort_valid", 32'(o_valid), 0);
    tick();
    start_frame();
    run_frame(-1, -1, vc, lo, di);
    check("t5_refr_valid", 32'(vc), 24);
    check("t5_refr_done_idx", 32'(di), 27);
    check("t5_refr_bitcnt", 32'(o_bit_cnt), 16);
    check("t5_q_empty", 32'(exp_q.size()), 0);

    // asynchronous reset mid-preamble, between clock edges
    tick();
    start_frame();
    tick(); tick();
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_valid", 32'(o_valid), 0);
    check("t6_rst_data", 32'(o_data), 0);
    check("t6_rst_busy", 32'(o_busy), 0);
    check("t6_rst_bitcnt", 32'(o_bit_cnt), 0);
    exp_q.delete();
    #3 rst_n = 1'b1;
    busy_seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (o_busy || o_valid) busy_seen++;
    end
    check("t6_no_restart", 32'(busy_seen), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/tx_frame_sequencer.md
Name: tx_frame_sequencer

Overview:
Frame-level controller ahead of the Pack -> Spread -> QPSK transmit chain.
On each start request it drives one frame into Pack as a serial bit stream: a fixed preamble, then PAYLOAD_LEN payload bits pulled from the upstream bit source.
After the frame it holds a guard interval, so the Spread/QPSK pipeline drains before the next frame.
It honours the Spread ready signal as backpressure and reports frame status.

Parameters:
PREAMBLE_LEN, 32, number of preamble bits (1..32)
PREAMBLE, 32'hF0F0_CC33, preamble pattern, sent MSB-first from bit PREAMBLE_LEN-1 down to bit 0
PAYLOAD_LEN, 256, payload bits per frame (>=1)
GUARD_CYCLES, 48, idle clocks after the last payload bit is accepted (>=1)
CNT_W, 16, counter width; must hold max(PAYLOAD_LEN, GUARD_CYCLES)

Ports:
i_clk  in  1  system clock
i_reset  in  1  asynchronous active-low reset
i_start  in  1  frame request pulse/level; sampled every clock
i_abort  in  1  abort the current frame; return to IDLE
i_bit  in  1  upstream payload bit
i_bit_valid  in  1  upstream bit valid
o_bit_ready  out  1  payload bit accepted when o_bit_ready && i_bit_valid
i_ready  in  1  downstream (Spread) ready
o_data  out  1  bit to Pack
o_valid  out  1  o_data valid; transfer occurs when o_valid && i_ready
o_busy  out  1  high in any state except IDLE
o_frame_done  out  1  one-clock pulse on GUARD -> exit
o_bit_cnt  out  CNT_W  payload bits transferred in the current frame

Behaviour:
- Reset (i_reset low, asynchronous): state=IDLE, o_valid=0, o_data=0, o_busy=0, o_frame_done=0, o_bit_cnt=0, start_pending=0, all counters 0.
- States: IDLE, PREAMBLE, PAYLOAD, GUARD.
- start_pending: set when i_start=1 in any state other than IDLE. Cleared when a frame is launched. Multiple requests collapse into one.
- IDLE -> PREAMBLE:
  - Condition: i_start || start_pending.
  - Next clock: o_valid=1 and o_data=PREAMBLE[PREAMBLE_LEN-1]. Latency from start to first o_valid is 1 clock.
- Output register: o_data/o_valid are registered. On a transfer (o_valid && i_ready) the register loads the next bit, or clears o_valid if none is available. With o_valid=1 and i_ready=0, o_data/o_valid hold stable.
- PREAMBLE:
  - Steps through the pattern on each transfer.
  - After the transfer of bit 0 the state becomes PAYLOAD.
  - The first payload bit may be loaded in the same clock if i_bit_valid=1.
- PAYLOAD:
  - o_bit_ready = (state==PAYLOAD) && (bits_loaded < PAYLOAD_LEN) && (!o_valid || i_ready). This is combinational.
  - An accepted bit loads o_data and sets o_valid=1.
  - Upstream stall (i_bit_valid=0) clears o_valid after the pending transfer. The state waits; there is no timeout.
  - o_bit_cnt increments on each downstream payload transfer.
  - After the transfer of payload bit PAYLOAD_LEN the state becomes GUARD: o_valid=0, guard counter=0.
- GUARD:
  - o_valid=0 for exactly GUARD_CYCLES clocks.
  - On the last cycle: o_frame_done=1 for one clock.
  - Next state: PREAMBLE if start_pending || i_start, else IDLE.
  - o_bit_cnt is cleared when the next PREAMBLE is entered and holds its final value in IDLE.
- i_abort:
  - Highest priority in any non-IDLE state: next clock state=IDLE, o_valid=0, start_pending=0, no o_frame_done.
  - o_bit_cnt holds its value.
  - An i_start in the same clock as i_abort is dropped.
- i_start while IDLE and i_abort asserted together: the abort wins and no frame starts.
- Reset asserted mid-frame: immediate return to reset values. The partial frame is not resumed.
- Counters never wrap within a frame, because CNT_W must cover the parameters.

Test Plan:
- Single frame, PREAMBLE_LEN=8, PREAMBLE=8'hA5, PAYLOAD_LEN=16, GUARD_CYCLES=4, i_ready=1, i_bit_valid=1:
  - o_data sequence 1,0,1,0,0,1,0,1 then the 16 upstream bits.
  - o_valid high for 24 consecutive clocks starting 1 clock after i_start.
  - Then 4 low clocks, with o_frame_done pulsing on the 4th; o_bit_cnt=16.
- Backpressure: i_ready toggles 1,0,0,1 repeatedly.
  - o_data holds stable while i_ready=0.
  - Output order is identical to the unstalled run, with no bits duplicated or lost; o_bit_cnt=16 at the end.
- Upstream stall: i_bit_valid=0 for 10 clocks after payload bit 5.
  - o_valid drops, the state stays PAYLOAD, and the frame resumes with bit 6.
  - Total payload transfers = 16.
- Back-to-back: i_start pulsed during PAYLOAD of frame 1.
  - Frame 2 preamble starts the clock after frame 1's o_frame_done.
  - The guard is exactly 4 clocks; a single start_pending yields only one extra frame.
- Abort: i_abort at payload bit 7.
  - Next clock o_valid=0, o_busy=0, no o_frame_done, o_bit_cnt=7.
  - A new i_start produces a full frame.
- Async reset asserted mid-PREAMBLE with no clock edge:
  - Outputs go to reset values immediately.
  - After release, no frame starts without i_start.
